pbv_alu: RTL and testbench



---
 rtl/pbv_alu_pkg.sv | 31 +++
 rtl/pbv_alu_datapath.sv | 92 +++++++++
 rtl/pbv_alu.sv | 81 ++++++++
 tb/tb_pbv_alu.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pbv_alu_pkg.sv
// pbv_alu_pkg: shared definitions for the PB-V ALU.
//   - Default datapath width.
//   - Opcode constants OP_ADD..OP_SLT (8-bit, all bits decoded).
//   - Flags struct carried from the datapath to the output registers.
package pbv_alu_pkg;

    localparam int unsigned PBV_ALU_WIDTH = 8;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_AND  = 8'h02;
    localparam logic [7:0] OP_OR   = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_NOT  = 8'h05;
    localparam logic [7:0] OP_SHL  = 8'h06;
    localparam logic [7:0] OP_SHR  = 8'h07;
    localparam logic [7:0] OP_INC  = 8'h08;
    localparam logic [7:0] OP_DEC  = 8'h09;
    localparam logic [7:0] OP_MUL  = 8'h0A;
    localparam logic [7:0] OP_PASS = 8'h0B;
    localparam logic [7:0] OP_SLT  = 8'h0C;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
        logic illegal_op;
    } pbv_flags_t;

endpackage

// File: rtl/pbv_alu_datapath.sv
// pbv_alu_datapath: purely combinational op/a/b -> result + flags.
// Ports:
//   op     in  8      opcode
//   a, b   in  WIDTH  operands (b ignored by unary ops, b[2:0] is the shift amount)
//   result out WIDTH  computed result
//   flags  out        zero/carry/negative/overflow/illegal_op
// Configuration: define PBV_ALU_MUL_EN to build the multiplier for OP_MUL;
// otherwise OP_MUL decodes as an illegal opcode.
module pbv_alu_datapath
    import pbv_alu_pkg::*;
#(
    parameter int unsigned WIDTH = PBV_ALU_WIDTH
) (
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output pbv_flags_t       flags
);

    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ovf;
    logic             illegal;
`ifdef PBV_ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
`endif

    // INC/DEC reuse the adder/subtractor with an implicit b of 1.
    assign opnd_b = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b;
    assign sum    = {1'b0, a} + {1'b0, opnd_b};
    assign diff   = {1'b0, a} - {1'b0, opnd_b};
    // One extra bit catches the last bit shifted out; it stays 0 for amount 0.
    assign shl_ext = {1'b0, a} << b[2:0];
    assign shr_ext = {a, 1'b0} >> b[2:0];
`ifdef PBV_ALU_MUL_EN
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

    always_comb begin
        res     = '0;
        cy      = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                ovf = (a[WIDTH-1] == opnd_b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                res = diff[WIDTH-1:0];
                cy  = diff[WIDTH];
                ovf = (a[WIDTH-1] != opnd_b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_SHL: begin
                res = shl_ext[WIDTH-1:0];
                cy  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res = shr_ext[WIDTH:1];
                cy  = shr_ext[0];
            end
`ifdef PBV_ALU_MUL_EN
            OP_MUL: begin
                res = prod[WIDTH-1:0];
                cy  = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            OP_PASS: res = b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: illegal = 1'b1;
        endcase
    end

    assign result           = res;
    assign flags.zero       = !illegal && (res == '0);
    assign flags.carry      = cy;
    assign flags.negative   = res[WIDTH-1];
    assign flags.overflow   = ovf;
    assign flags.illegal_op = illegal;

endmodule

// File: rtl/pbv_alu.sv
// pbv_alu: registered ALU with folded clock-enable, 1-cycle latency.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   enable             low freezes every register (acts as a gated clock)
//   in_valid, op, a, b request; sampled when enable && in_valid
//   result             registered result
//   out_valid          high for the cycle after an accepted request
//   zero, carry, negative, overflow, illegal_op  registered flags
// Configuration: PBV_ALU_MUL_EN enables the multiplier (see pbv_alu_datapath).
module pbv_alu
    import pbv_alu_pkg::*;
#(
    parameter int unsigned WIDTH = PBV_ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             illegal_op
);

    logic [WIDTH-1:0] dp_result;
    pbv_flags_t       dp_flags;

    logic [WIDTH-1:0] result_d, result_q;
    pbv_flags_t       flags_d, flags_q;
    logic             out_valid_d, out_valid_q;

    pbv_alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (dp_result),
        .flags  (dp_flags)
    );

    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        if (enable) begin
            out_valid_d = in_valid;
            if (in_valid) begin
                result_d = dp_result;
                flags_d  = dp_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result     = result_q;
    assign out_valid  = out_valid_q;
    assign zero       = flags_q.zero;
    assign carry      = flags_q.carry;
    assign negative   = flags_q.negative;
    assign overflow   = flags_q.overflow;
    assign illegal_op = flags_q.illegal_op;

endmodule

// File: tb/tb_pbv_alu.sv
// tb_pbv_alu: scoreboard bench for pbv_alu. Expected result/flags are pushed
// when a request is driven and popped when the DUT reports out_valid.
// Flags are compared as {zero, carry, negative, overflow, illegal_op}.
module tb_pbv_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       in_valid;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       out_valid;
    logic       zero;
    logic       carry;
    logic       negative;
    logic       overflow;
    logic       illegal_op;

    typedef struct {
        logic [7:0] res;
        logic [4:0] flg;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_valid = 1'b0;

    always #5 clk = ~clk;

    pbv_alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .op         (op),
        .a          (a),
        .b          (b),
        .result     (result),
        .out_valid  (out_valid),
        .zero       (zero),
        .carry      (carry),
        .negative   (negative),
        .overflow   (overflow),
        .illegal_op (illegal_op)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: track expected out_valid from the sampled controls and
    // pop the scoreboard whenever a fresh result appears.
    always @(posedge clk) begin
        logic en_s;
        logic iv_s;
        logic rs_s;
        logic fresh;
        exp_t e;
        en_s = enable;
        iv_s = in_valid;
        rs_s = rst_n;
        fresh = 1'b0;
        if (!rs_s) begin
            exp_valid = 1'b0;
        end else if (en_s) begin
            exp_valid = iv_s;
            fresh = iv_s;
        end
        #1;
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (fresh) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("result", {24'd0, result}, {24'd0, e.res});
                check_eq("flags", {27'd0, zero, carry, negative, overflow, illegal_op},
                         {27'd0, e.flg});
            end
        end
    end

    task automatic req(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic [4:0] ef);
        exp_t e;
        @(negedge clk);
        enable   = 1'b1;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        e.res    = er;
        e.flg    = ef;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        enable   = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b0;
        op       = 8'h00;
        a        = 8'h00;
        b        = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_result", {24'd0, result}, 32'd0);
        check_eq("rst_flags", {27'd0, zero, carry, negative, overflow, illegal_op}, 32'd0);
        rst_n = 1'b1;

        // Arithmetic
        req(8'h00, 8'hFF, 8'h01, 8'h00, 5'b11000);  // ADD carry out, zero
        req(8'h00, 8'h7F, 8'h01, 8'h80, 5'b00110);  // ADD signed overflow
        req(8'h01, 8'h05, 8'h07, 8'hFE, 5'b01100);  // SUB borrow
        req(8'h09, 8'h80, 8'h00, 8'h7F, 5'b00010);  // DEC overflow
        req(8'h08, 8'hFF, 8'h00, 8'h00, 5'b11000);  // INC wrap
        req(8'h0C, 8'h03, 8'h09, 8'h01, 5'b00000);  // SLT true
        // Shifts and unary
        req(8'h06, 8'h81, 8'h01, 8'h02, 5'b01000);  // SHL by 1
        req(8'h07, 8'h81, 8'h09, 8'h40, 5'b01000);  // SHR amount = b[2:0] = 1
        req(8'h06, 8'h81, 8'h08, 8'h81, 5'b00100);  // SHL amount 0: no carry
        req(8'h05, 8'h0F, 8'h00, 8'hF0, 5'b00100);  // NOT
        req(8'h0B, 8'h00, 8'h5A, 8'h5A, 5'b00000);  // PASS b
`ifdef PBV_ALU_MUL_EN
        req(8'h0A, 8'h10, 8'h10, 8'h00, 5'b11000);  // MUL upper bits set
`else
        req(8'h0A, 8'h10, 8'h10, 8'h00, 5'b00001);  // MUL not built
`endif
        req(8'h3F, 8'h12, 8'h34, 8'h00, 5'b00001);  // illegal
        req(8'h0D, 8'h12, 8'h34, 8'h00, 5'b00001);  // first code past SLT
        // Back-to-back logic ops
        req(8'h02, 8'hF0, 8'h3C, 8'h30, 5'b00000);
        req(8'h03, 8'hF0, 8'h0F, 8'hFF, 5'b00100);
        req(8'h04, 8'hFF, 8'h0F, 8'hF0, 5'b00100);

        // Freeze with a pending ADD 1+1: nothing changes, out_valid stays high.
        @(negedge clk);
        enable   = 1'b0;
        in_valid = 1'b1;
        op       = 8'h00;
        a        = 8'h01;
        b        = 8'h01;
        @(negedge clk);
        check_eq("freeze_result", {24'd0, result}, 32'h0000_00F0);
        check_eq("freeze_valid", {31'd0, out_valid}, 32'd1);
        enable   = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("idle_result", {24'd0, result}, 32'h0000_00F0);
        check_eq("idle_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-request: outputs clear at once, request is discarded.
        req(8'h00, 8'h22, 8'h33, 8'h55, 5'b00000);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_result", {24'd0, result}, 32'd0);
        check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        req(8'h00, 8'h01, 8'h02, 8'h03, 5'b00000);  // recovers after reset
        idle();
        idle();
        check_eq("sb_drain", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
